// File: rtl/serial_pattern_rx.sv
// rtl/serial_pattern_rx.sv - serial bit-stream receiver with selectable pattern detector
//
// Shifts qualified serial bits into a history register and compares the
// newest PAT_W bits against PAT0 or PAT1 (chosen by sel). Each match gives a
// one-cycle registered flag and bumps a saturating match counter.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_vld     in   1      qualifies in; a bit is consumed only when high
//   in         in   1      serial data bit (first bit received lands in the MSB)
//   sel        in   1      pattern select: 0 -> PAT0, 1 -> PAT1
//   overlap    in   1      1 keeps history after a match, 0 clears it
//   flag       out  1      one-cycle pulse in the cycle after a matching bit
//   match_cnt  out  CNT_W  matches since reset, saturating at all-ones
//   armed      out  1      history holds PAT_W valid bits
module serial_pattern_rx #(
    parameter int unsigned          PAT_W = 4,
    parameter logic [PAT_W-1:0]     PAT0  = 4'b1011,
    parameter logic [PAT_W-1:0]     PAT1  = 4'b0110,
    parameter int unsigned          CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             in,
    input  logic             sel,
    input  logic             overlap,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int unsigned         FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               sel_q;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_W-1:0]   hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic [PAT_W-1:0]   pat_sel;

    assign hist_shift = {hist_q[PAT_W-2:0], in};
    assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    // sel_q equals sel on every cycle that evaluates a match.
    assign pat_sel    = sel_q ? PAT1 : PAT0;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        flag_d = 1'b0;
        cnt_d  = cnt_q;

        if (sel != sel_q) begin
            // Pattern switch: restart history, the current bit (if any) is
            // the first of the new window and no match is checked.
            if (in_vld) begin
                hist_d = hist_shift;
                fill_d = FILL_W'(1);
            end else begin
                fill_d = '0;
            end
        end else if (in_vld) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if ((hist_shift == pat_sel) && (fill_inc == FILL_FULL)) begin
                flag_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!overlap) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end
        end

        // State is a pure function of the fill level.
        if (fill_d == '0) begin
            state_d = EMPTY;
        end else if (fill_d == FILL_FULL) begin
            state_d = ARMED;
        end else begin
            state_d = FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            hist_q  <= '0;
            fill_q  <= '0;
            sel_q   <= sel;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            sel_q   <= sel;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flag      = flag_q;
    assign match_cnt = cnt_q;
    assign armed     = (state_q == ARMED);

endmodule

// File: tb/tb_serial_pattern_rx.sv
// tb/tb_serial_pattern_rx.sv - directed self-checking bench for serial_pattern_rx
module tb_serial_pattern_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic       in_b;
    logic       sel;
    logic       overlap;
    logic       flag8, armed8;
    logic [7:0] cnt8;
    logic       flag2, armed2;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_pattern_rx #(.PAT_W(4), .PAT0(4'b1011), .PAT1(4'b0110), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in(in_b), .sel(sel),
        .overlap(overlap), .flag(flag8), .match_cnt(cnt8), .armed(armed8)
    );

    serial_pattern_rx #(.PAT_W(4), .PAT0(4'b1011), .PAT1(4'b0110), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in(in_b), .sel(sel),
        .overlap(overlap), .flag(flag2), .match_cnt(cnt2), .armed(armed2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic b);
        in_vld = v;
        in_b   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    logic [6:0] stream7;
    logic [6:0] exp_ov;
    logic [6:0] exp_nov;

    initial begin
        rst = 1'b0; in_vld = 1'b0; in_b = 1'b0; sel = 1'b0; overlap = 1'b1;
        stream7 = 7'b1011011;
        exp_ov  = 7'b0001001;
        exp_nov = 7'b0001000;

        // Reset state
        do_reset();
        check_eq("rst_flag", {31'd0, flag8}, 32'd0);
        check_eq("rst_cnt", {24'd0, cnt8}, 32'd0);
        check_eq("rst_armed", {31'd0, armed8}, 32'd0);

        // Basic match 1,0,1,1
        step(1'b1, 1'b1); check_eq("basic_b1", {31'd0, flag8}, 32'd0);
        step(1'b1, 1'b0); check_eq("basic_b2", {31'd0, flag8}, 32'd0);
        step(1'b1, 1'b1); check_eq("basic_b3", {31'd0, flag8}, 32'd0);
        check_eq("basic_armed3", {31'd0, armed8}, 32'd0);
        step(1'b1, 1'b1); check_eq("basic_flag", {31'd0, flag8}, 32'd1);
        check_eq("basic_cnt", {24'd0, cnt8}, 32'd1);
        check_eq("basic_armed", {31'd0, armed8}, 32'd1);
        step(1'b0, 1'b0); check_eq("basic_pulse_end", {31'd0, flag8}, 32'd0);

        // Overlapping detection
        do_reset();
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, stream7[i]);
            check_eq($sformatf("ovl_bit%0d", 7 - i), {31'd0, flag8}, {31'd0, exp_ov[i]});
        end
        check_eq("ovl_cnt", {24'd0, cnt8}, 32'd2);

        // Non-overlapping detection
        do_reset();
        overlap = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, stream7[i]);
            check_eq($sformatf("novl_bit%0d", 7 - i), {31'd0, flag8}, {31'd0, exp_nov[i]});
            if (i == 3) check_eq("novl_armed_after4", {31'd0, armed8}, 32'd0);
        end
        check_eq("novl_cnt", {24'd0, cnt8}, 32'd1);
        check_eq("novl_armed_end", {31'd0, armed8}, 32'd0);
        // fill was 3; one more bit arms without a match (hist 0111)
        step(1'b1, 1'b1);
        check_eq("novl_fill4_flag", {31'd0, flag8}, 32'd0);
        check_eq("novl_fill4_armed", {31'd0, armed8}, 32'd1);

        // in_vld gaps
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1); check_eq("gap_b1", {31'd0, flag8}, 32'd0);
        step(1'b1, 1'b0); check_eq("gap_b2", {31'd0, flag8}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check_eq($sformatf("gap_idle%0d", i), {31'd0, flag8}, 32'd0);
        end
        check_eq("gap_armed_idle", {31'd0, armed8}, 32'd0);
        step(1'b1, 1'b1); check_eq("gap_b3", {31'd0, flag8}, 32'd0);
        step(1'b1, 1'b1); check_eq("gap_flag", {31'd0, flag8}, 32'd1);
        check_eq("gap_cnt", {24'd0, cnt8}, 32'd1);
        step(1'b0, 1'b0); check_eq("gap_pulse_end", {31'd0, flag8}, 32'd0);

        // Pattern switch
        sel = 1'b0;
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        sel = 1'b1;
        step(1'b1, 1'b0); check_eq("sw_toggle", {31'd0, flag8}, 32'd0);
        step(1'b1, 1'b1); check_eq("sw_b2", {31'd0, flag8}, 32'd0);
        step(1'b1, 1'b1); check_eq("sw_b3_pat0_ignored", {31'd0, flag8}, 32'd0);
        step(1'b1, 1'b0); check_eq("sw_flag", {31'd0, flag8}, 32'd1);
        check_eq("sw_cnt", {24'd0, cnt8}, 32'd1);

        // Saturation with CNT_W=2: five overlapping matches
        sel = 1'b0;
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
        for (int m = 0; m < 4; m++) begin
            step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
        end
        check_eq("sat_flag2", {31'd0, flag2}, 32'd1);
        check_eq("sat_cnt2", {30'd0, cnt2}, 32'd3);
        check_eq("sat_cnt8", {24'd0, cnt8}, 32'd5);

        // Reset mid-stream: history 1101 with a 1 in the reset cycle would match
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        check_eq("mid_armed", {31'd0, armed8}, 32'd1);
        rst = 1'b1;
        step(1'b1, 1'b1);
        rst = 1'b0;
        check_eq("mid_rst_flag", {31'd0, flag8}, 32'd0);
        check_eq("mid_rst_cnt8", {24'd0, cnt8}, 32'd0);
        check_eq("mid_rst_cnt2", {30'd0, cnt2}, 32'd0);
        check_eq("mid_rst_armed", {31'd0, armed8}, 32'd0);
        step(1'b1, 1'b1);
        check_eq("post_rst_flag", {31'd0, flag8}, 32'd0);
        check_eq("post_rst_armed", {31'd0, armed8}, 32'd0);
        check_eq("post_rst_cnt", {24'd0, cnt8}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
